// File: rtl/clause_load_controller.sv
// Clause load controller: assembles clauses from a serial coefficient stream
// and writes each one into a bank of clause registers over a shared
// coefficient bus addressed by a one-cycle clause index.
module clause_load_controller #(
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = 2,
    parameter int unsigned NUMBER_OF_INTEGER_VARIABLES             = 2,
    parameter int unsigned NUMBER_OF_CLAUSES                       = 3,
    parameter int unsigned MAX_BIT_WIDTH_OF_CLAUSES_INDEX          = 1
) (
    input  logic                                  in_clk,
    input  logic                                  in_reset,
    input  logic                                  in_start,
    input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_coeff,
    input  logic                                  in_coeff_valid,
    output logic                                  out_coeff_ready,
    input  logic                                  in_coeff_last,
    output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT*(NUMBER_OF_INTEGER_VARIABLES+1)-1:0]
                                                  out_clause_coefficients,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_clause_index,
    output logic                                  out_busy,
    output logic                                  out_done,
    output logic                                  out_error,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_clauses_loaded
);

    localparam int unsigned CW = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
    localparam int unsigned N  = NUMBER_OF_INTEGER_VARIABLES;
    localparam int unsigned C  = NUMBER_OF_CLAUSES;
    localparam int unsigned IW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1;
    localparam int unsigned BW = CW * (N + 1);
    localparam int unsigned PW = (N > 0) ? $clog2(N + 1) : 1;

    localparam logic [IW-1:0] IDLE_INDEX  = '1;
    localparam logic [IW-1:0] LAST_CLAUSE = IW'(C - 1);
    localparam logic [PW-1:0] BIAS_POS    = PW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   pos_q;
    logic [IW-1:0]   clause_q;
    logic            last_q;
    logic [BW-1:0]   buffer_q;
    logic [BW-1:0]   buffer_d;
    logic            beat_accept;

    // Buffer with the current beat merged in at its position.
    always_comb begin
        beat_accept = in_coeff_valid && out_coeff_ready;
        buffer_d    = buffer_q;
        buffer_d[int'(pos_q) * CW +: CW] = in_coeff;
    end

    // Load-session FSM; every output is a register updated here.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q                 <= StIdle;
            pos_q                   <= '0;
            clause_q                <= '0;
            last_q                  <= 1'b0;
            buffer_q                <= '0;
            out_coeff_ready         <= 1'b0;
            out_clause_coefficients <= '0;
            out_clause_index        <= IDLE_INDEX;
            out_busy                <= 1'b0;
            out_done                <= 1'b0;
            out_error               <= 1'b0;
            out_clauses_loaded      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_start) begin
                        state_q            <= StCollect;
                        pos_q              <= '0;
                        clause_q           <= '0;
                        out_error          <= 1'b0;
                        out_clauses_loaded <= '0;
                        out_busy           <= 1'b1;
                        out_coeff_ready    <= 1'b1;
                    end
                end
                StCollect: begin
                    if (beat_accept) begin
                        buffer_q <= buffer_d;
                        if (pos_q == BIAS_POS) begin
                            // Bias completes the clause; last is judged after the write.
                            last_q                  <= in_coeff_last;
                            out_clause_coefficients <= buffer_d;
                            out_clause_index        <= clause_q;
                            out_coeff_ready         <= 1'b0;
                            state_q                 <= StWrite;
                        end else if (in_coeff_last) begin
                            // last before the bias: truncated clause, nothing written.
                            out_error       <= 1'b1;
                            out_done        <= 1'b1;
                            out_coeff_ready <= 1'b0;
                            state_q         <= StDone;
                        end else begin
                            pos_q <= pos_q + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    out_clause_index   <= IDLE_INDEX;
                    out_clauses_loaded <= clause_q + 1'b1;
                    pos_q              <= '0;
                    if (last_q) begin
                        out_done <= 1'b1;
                        state_q  <= StDone;
                    end else if (clause_q == LAST_CLAUSE) begin
                        // Bank is full but the stream never flagged its end.
                        out_error <= 1'b1;
                        out_done  <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        clause_q        <= clause_q + 1'b1;
                        out_coeff_ready <= 1'b1;
                        state_q         <= StCollect;
                    end
                end
                StDone: begin
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clause_load_controller.sv
// Directed bench for clause_load_controller with a write scoreboard.
module tb_clause_load_controller;

    logic       in_clk = 1'b0;
    logic       in_reset = 1'b1;
    logic       in_start = 1'b0;
    logic [1:0] in_coeff = '0;
    logic       in_coeff_valid = 1'b0;
    logic       in_coeff_last = 1'b0;
    logic       out_coeff_ready;
    logic [5:0] out_clause_coefficients;
    logic [1:0] out_clause_index;
    logic       out_busy;
    logic       out_done;
    logic       out_error;
    logic [1:0] out_clauses_loaded;

    clause_load_controller #(
        .MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT(2),
        .NUMBER_OF_INTEGER_VARIABLES(2),
        .NUMBER_OF_CLAUSES(3),
        .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(1)
    ) dut (
        .in_clk(in_clk),
        .in_reset(in_reset),
        .in_start(in_start),
        .in_coeff(in_coeff),
        .in_coeff_valid(in_coeff_valid),
        .out_coeff_ready(out_coeff_ready),
        .in_coeff_last(in_coeff_last),
        .out_clause_coefficients(out_clause_coefficients),
        .out_clause_index(out_clause_index),
        .out_busy(out_busy),
        .out_done(out_done),
        .out_error(out_error),
        .out_clauses_loaded(out_clauses_loaded)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [5:0] coeffs;
    } wr_t;

    wr_t exp_q[$];
    int  write_cycles[$];
    int  cycle = 0;
    int  done_cycles = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t mon_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: any non-idle index is a write and must match the next expected one.
    always @(negedge in_clk) begin
        cycle++;
        if (out_done === 1'b1) done_cycles++;
        if (out_clause_index !== 2'b11) begin
            write_cycles.push_back(cycle);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed index %0d coeffs %b expected no write",
                       out_clause_index, out_clause_coefficients);
            end
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                check("write_index", {30'd0, out_clause_index}, {30'd0, mon_w.idx});
                check("write_coeffs", {26'd0, out_clause_coefficients}, {26'd0, mon_w.coeffs});
            end
        end
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // Offer one beat and hold it until the DUT shows ready.
    task automatic send_beat(input logic [1:0] v, input logic l);
        int waited;
        waited = 0;
        in_coeff       = v;
        in_coeff_last  = l;
        in_coeff_valid = 1'b1;
        @(negedge in_clk);
        while (out_coeff_ready !== 1'b1 && waited < 20) begin
            @(negedge in_clk);
            waited++;
        end
        check("beat_ready", {31'd0, out_coeff_ready}, 32'd1);
        @(posedge in_clk);
        #1;
        in_coeff_valid = 1'b0;
        in_coeff_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        @(negedge in_clk);
        while (out_busy !== 1'b0 && waited < 50) begin
            @(negedge in_clk);
            waited++;
        end
        check(tag, {31'd0, out_busy}, 32'd0);
        tick();
    endtask

    task automatic check_session(input string tag, input int d0, input logic [1:0] loaded,
                                 input logic err);
        check({tag, "_done_pulse"}, done_cycles - d0, 32'd1);
        check({tag, "_loaded"}, {30'd0, out_clauses_loaded}, {30'd0, loaded});
        check({tag, "_error"}, {31'd0, out_error}, {31'd0, err});
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic full_load(input string tag);
        int d0;
        int wc0;
        d0  = done_cycles;
        wc0 = write_cycles.size();
        exp_q.push_back({2'd0, 6'b111001});
        exp_q.push_back({2'd1, 6'b100100});
        exp_q.push_back({2'd2, 6'b011111});
        pulse_start();
        check({tag, "_busy"}, {31'd0, out_busy}, 32'd1);
        send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b0); send_beat(2'd3, 1'b0);
        send_beat(2'd0, 1'b0); send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b0);
        send_beat(2'd3, 1'b0); send_beat(2'd3, 1'b0); send_beat(2'd1, 1'b1);
        wait_idle({tag, "_idle"});
        check_session(tag, d0, 2'd3, 1'b0);
        check({tag, "_writes"}, write_cycles.size() - wc0, 32'd3);
        if (write_cycles.size() == wc0 + 3) begin
            check({tag, "_gap01"}, write_cycles[wc0+1] - write_cycles[wc0], 32'd4);
            check({tag, "_gap12"}, write_cycles[wc0+2] - write_cycles[wc0+1], 32'd4);
        end
        check({tag, "_bus_hold"}, {26'd0, out_clause_coefficients}, {26'd0, 6'b011111});
        check({tag, "_idle_index"}, {30'd0, out_clause_index}, {30'd0, 2'b11});
    endtask

    initial begin
        int d0;

        // Reset state
        repeat (3) @(negedge in_clk);
        check("rst_index", {30'd0, out_clause_index}, {30'd0, 2'b11});
        check("rst_coeffs", {26'd0, out_clause_coefficients}, 32'd0);
        check("rst_ready", {31'd0, out_coeff_ready}, 32'd0);
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_done", {31'd0, out_done}, 32'd0);
        check("rst_error", {31'd0, out_error}, 32'd0);
        check("rst_loaded", {30'd0, out_clauses_loaded}, 32'd0);
        @(posedge in_clk);
        #1;
        in_reset = 1'b0;
        tick();

        // Full load of all three clauses
        full_load("full");

        // Early finish after one clause
        d0 = done_cycles;
        exp_q.push_back({2'd0, 6'b000110});
        pulse_start();
        send_beat(2'd2, 1'b0); send_beat(2'd1, 1'b0); send_beat(2'd0, 1'b1);
        wait_idle("early_idle");
        check_session("early", d0, 2'd1, 1'b0);

        // Framing error: last before the bias
        d0 = done_cycles;
        pulse_start();
        send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b1);
        wait_idle("frame_idle");
        check_session("frame", d0, 2'd0, 1'b1);
        d0 = done_cycles;
        pulse_start();
        check("frame_err_cleared", {31'd0, out_error}, 32'd0);
        exp_q.push_back({2'd0, 6'b010011});
        send_beat(2'd3, 1'b0); send_beat(2'd0, 1'b0); send_beat(2'd1, 1'b1);
        wait_idle("recover_idle");
        check_session("recover", d0, 2'd1, 1'b0);

        // Missing last: bank fills without a last beat
        d0 = done_cycles;
        exp_q.push_back({2'd0, 6'b000000});
        exp_q.push_back({2'd1, 6'b010101});
        exp_q.push_back({2'd2, 6'b101010});
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) send_beat(2'(i), 1'b0);
        end
        wait_idle("miss_idle");
        check_session("miss", d0, 2'd3, 1'b1);

        // Stalls and ignored in_start mid-session and during WRITE/DONE
        d0 = done_cycles;
        exp_q.push_back({2'd0, 6'b101101});
        pulse_start();
        send_beat(2'd1, 1'b0);
        repeat (2) tick();
        pulse_start();
        send_beat(2'd3, 1'b0);
        tick();
        send_beat(2'd2, 1'b1);
        in_start = 1'b1;
        repeat (2) tick();
        in_start = 1'b0;
        wait_idle("stall_idle");
        check_session("stall", d0, 2'd1, 1'b0);
        tick();
        check("stall_no_restart", {31'd0, out_busy}, 32'd0);

        // Async reset in the middle of a clause
        pulse_start();
        send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b0);
        #2;
        in_reset = 1'b1;
        #1;
        check("arst_index", {30'd0, out_clause_index}, {30'd0, 2'b11});
        check("arst_coeffs", {26'd0, out_clause_coefficients}, 32'd0);
        check("arst_ready", {31'd0, out_coeff_ready}, 32'd0);
        check("arst_busy", {31'd0, out_busy}, 32'd0);
        check("arst_loaded", {30'd0, out_clauses_loaded}, 32'd0);
        @(posedge in_clk);
        #1;
        in_reset = 1'b0;
        tick();
        full_load("post_rst");

        check("final_pending", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clause_load_controller.md
Name: clause_load_controller

Overview:
- Sequences loading of a bank of integer-literal clause registers from a serial coefficient stream.
- Accepts one coefficient per valid/ready beat and assembles a full clause (NUMBER_OF_INTEGER_VARIABLES coefficients plus bias).
- Broadcasts the assembled clause on the shared coefficient bus and drives the shared clause index for exactly one cycle, so only the addressed register captures it.
- Holds the index at the reserved idle address at all other times.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT, 2, width CW of one coefficient.
- NUMBER_OF_INTEGER_VARIABLES, 2, variables per clause (N); the clause holds N+1 coefficients including bias.
- NUMBER_OF_CLAUSES, 3, clause registers in the bank (C). Must satisfy C <= 2^(W+1)-1.
- MAX_BIT_WIDTH_OF_CLAUSES_INDEX, 1, W; the index bus is W+1 bits, and all-ones is the idle/no-write address.

Ports:
- in_clk  input  1  clock; all state on rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  one-cycle pulse; begins a load session.
- in_coeff  input  CW  coefficient beat.
- in_coeff_valid  input  1  in_coeff is valid.
- out_coeff_ready  output  1  controller accepts the beat this cycle.
- in_coeff_last  input  1  qualifies a beat; marks the final coefficient of the final clause.
- out_clause_coefficients  output  CW*(N+1)  assembled clause, to the register bank.
- out_clause_index  output  W+1  target clause id; all-ones means idle.
- out_busy  output  1  session in progress.
- out_done  output  1  one-cycle pulse at end of session.
- out_error  output  1  sticky framing error, cleared by the next accepted in_start.
- out_clauses_loaded  output  W+1  clauses written in current/last session.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - out_clause_index = all-ones.
  - out_clause_coefficients = 0.
  - out_coeff_ready, out_busy, out_done, out_error = 0.
  - out_clauses_loaded = 0.
  - The coefficient position counter clears. A partial clause is discarded and no write occurs.
- All outputs are registered.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - ready=0.
  - in_start -> COLLECT. Clears position counter, clause counter, out_error and out_clauses_loaded. out_busy=1 from the next cycle.
- COLLECT:
  - ready=1. A beat is accepted when valid&&ready.
  - The accepted coefficient at position p (0..N) is stored at bits [p*CW +: CW]; position N is the bias.
  - Accepted at p<N with last=0: p increments.
  - Accepted at p<N with last=1: framing error. out_error=1 and go to DONE with no write.
  - Accepted at p=N: go to WRITE. last is evaluated and recorded.
  - in_start is ignored while busy.
- WRITE (exactly one cycle):
  - ready=0. out_clause_index = clause counter k and out_clause_coefficients = buffer, both valid this cycle only.
  - Next cycle: index returns to all-ones and the coefficient bus holds its value. out_clauses_loaded = k+1 and p = 0.
  - Recorded last=1: go to DONE.
  - Else if k = C-1: go to DONE and set out_error=1 (missing last).
  - Else: k increments and go to COLLECT.
- DONE (one cycle):
  - out_done=1 and ready=0.
  - Next cycle: go to IDLE and out_busy=0.
  - in_start in DONE is ignored.
- Throughput: N+1 beats plus 1 write cycle per clause with back-to-back valid.
- Latency: from acceptance of the bias beat to index valid is 1 cycle.
- last on the final coefficient of clause C-1 is the normal completion (no error).
- Clause counter never wraps: a session writes at most C clauses, and the index never equals all-ones during WRITE.
- valid with ready=0 (IDLE, WRITE, DONE): the beat is not consumed, and the source must hold it.

Test Plan (defaults CW=2, N=2, C=3, W=1, idle index 2'b11):
- Full load: start, then beats 1,2,3 | 0,1,2 | 3,3,1 (last on final) -> index 0 with coeffs 6'b111001, index 1 with 6'b100100, index 2 with 6'b011111, each for one cycle 4 cycles apart. out_done pulses. loaded=3, error=0.
- Early finish: start, beats 2,1,0 with last on third -> one write to index 0 with 6'b000110. done, loaded=1, error=0.
- Framing error: start, beats 1 then 2 with last -> no write (index stays 2'b11). error=1, done pulses, loaded=0. Next start clears error.
- Missing last: three full clauses with last never asserted -> three writes. done, error=1, loaded=3.
- Stall/handshake: valid toggling and in_start pulsed mid-session -> assembled clause unchanged, start ignored. Beats offered in the WRITE cycle are not consumed.
- Async reset asserted during COLLECT after 2 beats -> outputs at reset values immediately, no write. A subsequent full session behaves normally.
